// File: rtl/tb_seq_pkg.sv
// tb_seq_pkg: command/status codes and channel FSM states shared by tb_seq_ctrl.
package tb_seq_pkg;
  typedef logic [1:0] tb_code_t;
  localparam tb_code_t TB_DONE = 2'b00;
  localparam tb_code_t TB_ONCE = 2'b01;
  localparam tb_code_t TB_LOOPING = 2'b10;
  localparam tb_code_t TB_ABORT = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_ONCE, S_LOOP} state_t;
endpackage

// File: rtl/tb_seq_channel.sv
// tb_seq_channel: one trigger/status handshake channel; busy_cycles counter built only with TB_SEQ_STATS_EN.
module tb_seq_channel import tb_seq_pkg::*; #(
  parameter int CNT_W = 16,
  parameter int LOOP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        trigger,
  input  logic [LOOP_W-1:0] loop_limit,
  input  logic              seq_done,
  output logic [1:0]        status,
  output logic              seq_start,
  output logic              done_pulse,
  output logic              reject,
  output logic [CNT_W-1:0]  run_count,
  output logic [CNT_W-1:0]  busy_cycles
);
  state_t state, state_nx;
  tb_code_t prev;
  logic [LOOP_W-1:0] iter;
  logic go, abort, again, start_nx, done_nx, rej_nx;
  assign go = trigger != prev && (trigger == TB_ONCE || trigger == TB_LOOPING);
  assign abort = trigger != prev && trigger == TB_ABORT;
  assign again = loop_limit == '0 || iter < loop_limit;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      prev <= TB_DONE;
      seq_start <= 1'b0;
      done_pulse <= 1'b0;
      reject <= 1'b0;
      run_count <= '0;
      iter <= '0;
    end else begin
      state <= state_nx;
      prev <= trigger;
      seq_start <= start_nx;
      done_pulse <= done_nx;
      reject <= rej_nx;
      run_count <= run_count + CNT_W'(start_nx && run_count != '1);
      if (start_nx) iter <= (state == S_IDLE) ? LOOP_W'(1) : iter + LOOP_W'(iter != '1);
    end
  end
  // abort outranks seq_done, so a simultaneous completion never restarts
  always_comb begin
    state_nx = state;
    if (state == S_IDLE)
      state_nx = go ? (trigger == TB_ONCE ? S_ONCE : S_LOOP) : S_IDLE;
    else if (abort || (seq_done && (state == S_ONCE || !again)))
      state_nx = S_IDLE;
  end
  always_comb begin
    start_nx = (state == S_IDLE && go) || (state == S_LOOP && !abort && seq_done && again);
    done_nx = state != S_IDLE && state_nx == S_IDLE && run_count != '0;
    rej_nx = state != S_IDLE && go;
    status = state == S_LOOP ? TB_LOOPING : state == S_ONCE ? TB_ONCE : TB_DONE;
  end
`ifdef TB_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) busy_cycles <= '0;
    else busy_cycles <= busy_cycles + CNT_W'(state != S_IDLE && busy_cycles != '1);
  end
`else
  assign busy_cycles = '0;
`endif
endmodule

// File: rtl/tb_seq_ctrl.sv
// tb_seq_ctrl: NUM_CH independent sequence trigger channels; optional busy stats via TB_SEQ_STATS_EN.
module tb_seq_ctrl import tb_seq_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 16,
  parameter int LOOP_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*NUM_CH-1:0]     trigger,
  input  logic [LOOP_W*NUM_CH-1:0] loop_limit,
  input  logic [NUM_CH-1:0]       seq_done,
  output logic [2*NUM_CH-1:0]     status,
  output logic [NUM_CH-1:0]       seq_start,
  output logic [NUM_CH-1:0]       done_pulse,
  output logic [NUM_CH-1:0]       reject,
  output logic [CNT_W*NUM_CH-1:0] run_count,
  output logic [CNT_W*NUM_CH-1:0] busy_cycles
);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    tb_seq_channel #(.CNT_W(CNT_W), .LOOP_W(LOOP_W)) u_ch (
      .clk(clk),
      .rst(rst),
      .trigger(trigger[2*c +: 2]),
      .loop_limit(loop_limit[LOOP_W*c +: LOOP_W]),
      .seq_done(seq_done[c]),
      .status(status[2*c +: 2]),
      .seq_start(seq_start[c]),
      .done_pulse(done_pulse[c]),
      .reject(reject[c]),
      .run_count(run_count[CNT_W*c +: CNT_W]),
      .busy_cycles(busy_cycles[CNT_W*c +: CNT_W])
    );
  end
endmodule

// File: doc/tb_seq_ctrl.md
# tb_seq_ctrl

Synthesizable, multi-channel successor to the single-channel testbench trigger/status handshake. Each of `NUM_CH` independent channels accepts ONCE / LOOPING / ABORT commands, reports DONE / ONCE / LOOPING status, and counts transaction runs. Looping runs may be bounded by a per-channel iteration limit. The block sits between the pipeline-processor test harness and the stimulus sequences it launches, with one sequence body per channel.

## Interface
- `NUM_CH`, 4: number of independent channels.
- `CNT_W`, 16: width of each run counter and of each busy-cycle counter.
- `LOOP_W`, 8: width of each loop-limit field.
- `clk` input 1: the single clock.
- `rst` input 1: synchronous reset, active-high.
- `trigger` input 2*NUM_CH: per-channel command code. Channel i occupies bits [2i+1:2i].
- `loop_limit` input LOOP_W*NUM_CH: iterations per LOOPING run. 0 means unbounded.
- `seq_done` input NUM_CH: one-cycle pulse from the sequence body when its current iteration completes.
- `status` output 2*NUM_CH: per-channel status code.
- `seq_start` output NUM_CH: one-cycle pulse that launches one iteration.
- `done_pulse` output NUM_CH: one-cycle pulse on entry to DONE, issued only if that channel's run_count > 0.
- `reject` output NUM_CH: one-cycle pulse when a start command arrives while the channel is already running.
- `run_count` output CNT_W*NUM_CH: per-channel count of started iterations.
- `busy_cycles` output CNT_W*NUM_CH: statistics counters (see Configuration).

## Operation
- **Codes:** DONE=2'b00, ONCE=2'b01, LOOPING=2'b10, ABORT=2'b11.
- **Command detection:** a channel acts on a command only when its trigger value differs from its registered previous value, i.e. on trigger change only. A held trigger does not re-fire.
- **Per-channel FSM states:** IDLE (status DONE), RUN_ONCE, RUN_LOOP. Let iter be an internal iteration counter of width LOOP_W.
- **IDLE:**
  - Change to ONCE: go to RUN_ONCE, pulse seq_start, run_count+1.
  - Change to LOOPING: go to RUN_LOOP, pulse seq_start, run_count+1, iter=1.
  - Change to ABORT or DONE: no action, no done_pulse.
- **RUN_ONCE:** on seq_done, go to IDLE and pulse done_pulse.
- **RUN_LOOP:** on seq_done:
  - If loop_limit==0 or iter<loop_limit: pulse seq_start, run_count+1, iter+1, stay in RUN_LOOP.
  - Otherwise go to IDLE and pulse done_pulse.
- **Running + change to ONCE/LOOPING:** pulse reject. State, status and counters are unchanged.
- **Any running state + change to ABORT:** go to IDLE and pulse done_pulse. ABORT has priority over a seq_done in the same cycle, so no restart is issued.
- **Running + change to DONE:** ignored.
- **Arithmetic:** run_count saturates at all-ones and does not wrap. iter saturates likewise.
- **loop_limit sampling:** sampled each time seq_done arrives, not latched at start.
- **seq_done in IDLE:** ignored.
- **Channel independence:** channels are fully independent and all may switch in the same cycle.

## Timing
- Trigger change at edge N: status, seq_start, reject and run_count update at edge N+1, i.e. registered with 1-cycle latency.
- seq_done at edge N: the restart seq_start or done_pulse is visible after edge N+1.
- Minimum iteration period: 2 cycles (seq_start at cycle N, seq_done at N+1, next seq_start at N+2).
- **Reset values:**
  - status = DONE; seq_start, done_pulse and reject = 0.
  - run_count, busy_cycles and iter = 0.
  - Previous-trigger register = DONE.
- **Reset mid-run:** returns the channel to IDLE immediately, with no done_pulse.
- **Trigger held through reset:** a trigger held at ONCE through reset fires on the first cycle after rst falls.

## Configuration
- `TB_SEQ_STATS_EN` defined: each busy_cycles counter increments on every cycle its channel is in RUN_ONCE or RUN_LOOP. It saturates, is not cleared on run start, and is cleared only by rst.
- `TB_SEQ_STATS_EN` undefined: busy_cycles is driven constant 0, no counter logic is built, and the port list is unchanged.

## Structure
- **Package `tb_seq_pkg`:** status/command code constants (TB_DONE, TB_ONCE, TB_LOOPING, TB_ABORT) and the 2-bit typedef `tb_code_t`. The FSM state enum also lives here.
- **Sub-module `tb_seq_channel`:** one per channel, holding the FSM, counters and change detect. The top level is a generate loop that slices the flattened buses.

## Test plan
- Reset, then ch0 trigger DONE→ONCE → next cycle: status0=01, seq_start0 pulse, run_count0=1. seq_done0 → status0=00, done_pulse0.
- ch1 LOOPING with loop_limit=3, seq_done each 2 cycles → exactly 3 seq_start pulses, run_count1=3, then status1=00 with one done_pulse.
- ch2 running ONCE, trigger changed to LOOPING → reject2 pulse; status2 stays 01 and run_count2 stays 1.
- ch3 LOOPING with loop_limit=0, ABORT and seq_done asserted in the same cycle → status3=00 and done_pulse3, with no restart seq_start.
- rst asserted mid-LOOP on ch0 with the trigger held at LOOPING → all outputs zero. After release, ch0 restarts once with run_count0=1.
- With `TB_SEQ_STATS_EN`, a ONCE run lasting 5 cycles → busy_cycles=5. Without the macro, busy_cycles=0.
